bram_controller: RTL and testbench

BRAM_CONTROLLER -- requirements
Module: bram_controller

---
 rtl/bram_controller_if.sv | 61 ++++++
 rtl/bram_controller.sv | 142 ++++++++++++++
 tb/tb_bram_controller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_controller_if.sv
// rtl/bram_controller_if.sv - AXI4-Lite slave bus bundle for bram_controller
//
// Carries the five AXI4-Lite channels (AW, W, B, AR, R).
//   master modport: driven by the bus initiator (addresses, data, valids, bready/rready)
//   slave  modport: driven by bram_controller (readies, responses, read data)
// awprot/arprot are carried for completeness.

interface bram_controller_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [2:0]              s_axi_awprot;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;

    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;

    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;

    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [2:0]              s_axi_arprot;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;

    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );
endinterface

// File: rtl/bram_controller.sv
// rtl/bram_controller.sv - AXI4-Lite slave to single-port BRAM bridge
//
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, asynchronous active-low reset
//   s_axi                     : AXI4-Lite slave bus (bram_controller_if.slave)
//   bram_clk_a, bram_rst_a    : BRAM port clock (= aclk) and reset (= !aresetn)
//   bram_en_a, bram_we_a      : BRAM enable and byte write enables
//   bram_addr_a               : BRAM byte address (word aligned)
//   bram_wrdata_a             : BRAM write data
//   bram_rddata_a             : BRAM read data, one cycle after the enable
//
// Optional feature macro: BRAM_CTRL_ADDR_CHECK_EN
//   defined   : misaligned addresses skip the BRAM cycle and return SLVERR
//   undefined : low address bits are cleared and every response is OKAY

module bram_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    bram_controller_if.slave        s_axi,
    output logic                    bram_clk_a,
    output logic                    bram_rst_a,
    output logic                    bram_en_a,
    output logic [DATA_WIDTH/8-1:0] bram_we_a,
    output logic [ADDR_WIDTH-1:0]   bram_addr_a,
    output logic [DATA_WIDTH-1:0]   bram_wrdata_a,
    input  logic [DATA_WIDTH-1:0]   bram_rddata_a
);
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = {{(ADDR_WIDTH-2){1'b0}}, 2'b11};

    typedef enum logic [2:0] {
        IDLE, WR_BRAM, WR_RESP, RD_BRAM, RD_LATCH, RD_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    wr_first_q, wr_first_d;  // round-robin: write wins a tie when set

    logic wr_req, rd_req, grant_wr, grant_rd;
    logic aw_err, ar_err;
    logic unused_prot;

    assign unused_prot = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot};

    assign wr_req   = s_axi.s_axi_awvalid && s_axi.s_axi_wvalid;
    assign rd_req   = s_axi.s_axi_arvalid;
    assign grant_wr = (state_q == IDLE) && wr_req && (wr_first_q || !rd_req);
    assign grant_rd = (state_q == IDLE) && rd_req && (!wr_first_q || !wr_req);

`ifdef BRAM_CTRL_ADDR_CHECK_EN
    assign aw_err = |(s_axi.s_axi_awaddr & LSB_MASK);
    assign ar_err = |(s_axi.s_axi_araddr & LSB_MASK);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wr_first_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wr_first_q <= wr_first_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wr_first_d = wr_first_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d    = WR_BRAM;
                    err_d      = aw_err;
                    strb_d     = s_axi.s_axi_wstrb;
                    wr_first_d = 1'b0;
                    // A rejected access leaves the BRAM port values untouched.
                    if (!aw_err) begin
                        addr_d  = s_axi.s_axi_awaddr & ~LSB_MASK;
                        wdata_d = s_axi.s_axi_wdata;
                    end
                end else if (grant_rd) begin
                    state_d    = RD_BRAM;
                    err_d      = ar_err;
                    wr_first_d = 1'b1;
                    if (!ar_err) begin
                        addr_d = s_axi.s_axi_araddr & ~LSB_MASK;
                    end
                end
            end
            WR_BRAM:  state_d = WR_RESP;
            WR_RESP:  if (s_axi.s_axi_bready) state_d = IDLE;
            RD_BRAM:  state_d = RD_LATCH;
            RD_LATCH: begin
                // BRAM data is valid here, one cycle after the enable.
                rdata_d = err_q ? '0 : bram_rddata_a;
                state_d = RD_RESP;
            end
            RD_RESP:  if (s_axi.s_axi_rready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Readies are gated by reset so they stay low while reset is held.
    assign s_axi.s_axi_awready = grant_wr && s_axi_aresetn;
    assign s_axi.s_axi_wready  = grant_wr && s_axi_aresetn;
    assign s_axi.s_axi_arready = grant_rd && s_axi_aresetn;
    assign s_axi.s_axi_bvalid  = (state_q == WR_RESP);
    assign s_axi.s_axi_bresp   = ((state_q == WR_RESP) && err_q) ? 2'b10 : 2'b00;
    assign s_axi.s_axi_rvalid  = (state_q == RD_RESP);
    assign s_axi.s_axi_rresp   = ((state_q == RD_RESP) && err_q) ? 2'b10 : 2'b00;
    assign s_axi.s_axi_rdata   = rdata_q;

    assign bram_clk_a    = s_axi_aclk;
    assign bram_rst_a    = !s_axi_aresetn;
    assign bram_en_a     = ((state_q == WR_BRAM) || (state_q == RD_BRAM)) && !err_q;
    assign bram_we_a     = ((state_q == WR_BRAM) && !err_q) ? strb_q : '0;
    assign bram_addr_a   = addr_q;
    assign bram_wrdata_a = wdata_q;
endmodule

// File: tb/tb_bram_controller.sv
// tb/tb_bram_controller.sv - self-checking bench for bram_controller
module tb_bram_controller;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          bram_clk, bram_rst, bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wrdata, bram_rddata;

    bram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi         (bus),
        .bram_clk_a    (bram_clk),
        .bram_rst_a    (bram_rst),
        .bram_en_a     (bram_en),
        .bram_we_a     (bram_we),
        .bram_addr_a   (bram_addr),
        .bram_wrdata_a (bram_wrdata),
        .bram_rddata_a (bram_rddata)
    );

    // Environment: 64-word BRAM with one-cycle read latency.
    logic [DW-1:0] bram_mem [0:63];
    logic          bram_clr = 1'b1;
    always @(posedge bram_clk) begin
        if (bram_clr) begin
            for (int i = 0; i < 64; i++) bram_mem[i] <= '0;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram_mem[bram_addr[7:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
            bram_rddata <= bram_mem[bram_addr[7:2]];
        end
    end

    // Reference model: word contents as seen by the AXI master.
    logic [DW-1:0] ref_mem [0:63];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit misaligned_err(input logic [AW-1:0] a);
`ifdef BRAM_CTRL_ADDR_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int bdly);
        int n;
        bit err;
        err = misaligned_err(addr);
        @(negedge clk);
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awprot  = 3'($urandom);
        bus.s_axi_wdata   = data;
        bus.s_axi_wstrb   = strb;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_bready  = 1'b0;
        #1;
        n = 0;
        while (!(bus.s_axi_awready && bus.s_axi_wready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("wr_accept_first_idle", 32'(n), 32'd0);
        if (n >= 20) begin
            bus.s_axi_awvalid = 1'b0;
            bus.s_axi_wvalid  = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        @(negedge clk);
        chk("wr_bram_en", 32'(bram_en), err ? 32'd0 : 32'd1);
        chk("wr_bram_we", 32'(bram_we), err ? 32'd0 : 32'(strb));
        if (!err) begin
            chk("wr_bram_addr", 32'(bram_addr), 32'(addr & 16'hFFFC));
            chk("wr_bram_wrdata", bram_wrdata, data);
        end
        chk("wr_bvalid_early", 32'(bus.s_axi_bvalid), 32'd0);
        @(negedge clk);
        chk("wr_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        chk("wr_bresp", 32'(bus.s_axi_bresp), err ? 32'd2 : 32'd0);
        chk("wr_bram_en_idle", 32'(bram_en), 32'd0);
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("wr_bvalid_hold", 32'(bus.s_axi_bvalid), 32'd1);
        end
        bus.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b0;
        if (!err)
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int rdly, input bit hold_ar,
                           output logic [31:0] got);
        int n;
        bit err;
        logic [31:0] expv;
        err  = misaligned_err(addr);
        expv = err ? 32'd0 : ref_mem[addr[7:2]];
        got  = 'x;
        @(negedge clk);
        bus.s_axi_araddr  = addr;
        bus.s_axi_arprot  = 3'($urandom);
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready  = 1'b0;
        #1;
        n = 0;
        while (!bus.s_axi_arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("rd_accept_first_idle", 32'(n), 32'd0);
        if (n >= 20) begin
            bus.s_axi_arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
        @(negedge clk);
        chk("rd_bram_en", 32'(bram_en), err ? 32'd0 : 32'd1);
        chk("rd_bram_we", 32'(bram_we), 32'd0);
        if (!err) chk("rd_bram_addr", 32'(bram_addr), 32'(addr & 16'hFFFC));
        chk("rd_rvalid_c1", 32'(bus.s_axi_rvalid), 32'd0);
        @(negedge clk);
        chk("rd_rvalid_c2", 32'(bus.s_axi_rvalid), 32'd0);
        chk("rd_bram_en_c2", 32'(bram_en), 32'd0);
        @(negedge clk);
        chk("rd_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
        chk("rd_rdata", bus.s_axi_rdata, expv);
        chk("rd_rresp", 32'(bus.s_axi_rresp), err ? 32'd2 : 32'd0);
        got = bus.s_axi_rdata;
        if (hold_ar) begin
            bus.s_axi_araddr  = 16'($urandom_range(0, 255));
            bus.s_axi_arvalid = 1'b1;
        end
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("rd_rvalid_hold", 32'(bus.s_axi_rvalid), 32'd1);
            chk("rd_rdata_hold", bus.s_axi_rdata, expv);
            chk("rd_no_arready", 32'(bus.s_axi_arready), 32'd0);
        end
        bus.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_rready  = 1'b0;
        bus.s_axi_arvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        bus.s_axi_awaddr  = '0; bus.s_axi_awprot = '0;
        bus.s_axi_wdata   = '0; bus.s_axi_wstrb  = '0;
        bus.s_axi_araddr  = '0; bus.s_axi_arprot = '0;
        bus.s_axi_bready  = 1'b0; bus.s_axi_rready = 1'b0;
        // Requests held high during reset must not be accepted.
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        repeat (3) @(negedge clk);
        bram_clr = 1'b0;
        #1;
        chk("rst_awready", 32'(bus.s_axi_awready), 32'd0);
        chk("rst_wready", 32'(bus.s_axi_wready), 32'd0);
        chk("rst_arready", 32'(bus.s_axi_arready), 32'd0);
        chk("rst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
        chk("rst_resp", 32'({bus.s_axi_bresp, bus.s_axi_rresp}), 32'd0);
        chk("rst_rdata", bus.s_axi_rdata, 32'd0);
        chk("rst_bram_en_we", 32'({bram_en, bram_we}), 32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_bram_wrdata", bram_wrdata, 32'd0);
        chk("rst_bram_rst", 32'(bram_rst), 32'd1);
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("bram_rst_released", 32'(bram_rst), 32'd0);

        // Arbitration: all requests held high; expect write, read, write.
        @(negedge clk);
        bus.s_axi_awaddr = 16'h0020; bus.s_axi_wdata = 32'h11112222; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_araddr = 16'h0020;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
        #1;
        chk("arb1_awready", 32'(bus.s_axi_awready), 32'd1);
        chk("arb1_arready", 32'(bus.s_axi_arready), 32'd0);
        @(posedge clk); #1;
        bus.s_axi_awaddr = 16'h0024; bus.s_axi_wdata = 32'h33334444;
        @(negedge clk);
        @(negedge clk);
        chk("arb1_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        @(negedge clk); #1;
        chk("arb2_arready", 32'(bus.s_axi_arready), 32'd1);
        chk("arb2_awready", 32'(bus.s_axi_awready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("arb2_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
        chk("arb2_rdata", bus.s_axi_rdata, 32'h11112222);
        @(negedge clk); #1;
        chk("arb3_awready", 32'(bus.s_axi_awready), 32'd1);
        chk("arb3_arready", 32'(bus.s_axi_arready), 32'd0);
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        bus.s_axi_bready = 1'b0;
        ref_mem[8] = 32'h11112222;
        ref_mem[9] = 32'h33334444;
        do_read(16'h0024, 0, 1'b0, got);
        chk("arb3_write_landed", got, 32'h33334444);

        // Directed data-path cases.
        do_write(16'h0010, 32'hDEADBEEF, 4'hF, 0);
        do_read(16'h0010, 0, 1'b0, got);
        chk("read_after_write", got, 32'hDEADBEEF);
        do_write(16'h0010, 32'h000000AA, 4'h1, 2);
        do_read(16'h0010, 1, 1'b0, got);
        chk("byte_strobe_merge", got, 32'hDEADBEAA);
        do_read(16'h0012, 0, 1'b0, got);
`ifdef BRAM_CTRL_ADDR_CHECK_EN
        chk("misaligned_read", got, 32'h0);
`else
        chk("misaligned_read", got, 32'hDEADBEAA);
`endif
        do_read(16'h0010, 5, 1'b1, got);
        do_write(16'h0014, 32'h12345678, 4'h0, 0);
        do_read(16'h0014, 0, 1'b0, got);
        chk("zero_strobe_no_change", got, 32'h0);

        // Reset during a pending write response: no response, write-first restored.
        do_write(16'h0030, 32'hCAFEF00D, 4'hF, 0);
        @(negedge clk);
        bus.s_axi_awaddr = 16'h0034; bus.s_axi_wdata = 32'h55AA55AA; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[13] = 32'h55AA55AA;
        @(negedge clk);
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        #1;
        chk("post_reset_write_first", 32'(bus.s_axi_awready), 32'd1);
        chk("post_reset_read_waits", 32'(bus.s_axi_arready), 32'd0);
        #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        do_read(16'h0030, 0, 1'b0, got);
        chk("survives_reset", got, 32'hCAFEF00D);

        // Randomised traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            logic [AW-1:0] a;
            a = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
            else
                do_read(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
